// File: rtl/reset_sequencer.sv
// reset_sequencer: holds all domain resets, then releases them one by one in ascending order.
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  sync_reset_n,
  input  logic                  i_start,
  input  logic                  i_hold,
  output logic [NUM_STAGES-1:0] o_stage_reset,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int MX   = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = MX > 1 ? $clog2(MX) : 1;
  localparam int IW   = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  localparam int LAST = NUM_STAGES > 1 ? NUM_STAGES - 2 : 0;
  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, DONE} state_t;
  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [NUM_STAGES-1:0] w_rst_nxt;
  logic                  w_busy_nxt, w_done_nxt, w_hold_end, w_gap_end, w_last, w_adv;
  assign w_hold_end = r_cnt == CW'(HOLD_CYCLES - 1);
  assign w_gap_end  = r_cnt == CW'(GAP_CYCLES - 1);
  assign w_last     = r_idx == IW'(LAST);
  assign w_adv      = (r_state == ASSERT && !i_hold && w_hold_end) || (r_state == RELEASE && w_gap_end);
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      r_state       <= ASSERT;
      r_cnt         <= '0;
      r_idx         <= '0;
      o_stage_reset <= '1;
      o_busy        <= 1'b1;
      o_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      o_stage_reset <= w_rst_nxt;
      o_busy        <= w_busy_nxt;
      o_done        <= w_done_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        w_state_nxt = i_start ? ASSERT : IDLE;
        w_cnt_nxt   = i_start ? '0 : r_cnt;
      end
      ASSERT: begin
        w_state_nxt = w_adv ? (NUM_STAGES == 1 ? DONE : RELEASE) : ASSERT;
        w_cnt_nxt   = w_adv ? '0 : (i_hold ? r_cnt : CW'(r_cnt + 1'b1));
        w_idx_nxt   = w_adv ? '0 : r_idx;
      end
      RELEASE: begin
        w_state_nxt = w_adv && w_last ? DONE : RELEASE;
        w_cnt_nxt   = w_adv ? '0 : CW'(r_cnt + 1'b1);
        w_idx_nxt   = w_adv ? IW'(r_idx + 1'b1) : r_idx;
      end
      DONE: w_state_nxt = IDLE;
    endcase
  end
  // Ascending release means each advance simply shifts another zero in from bit 0.
  always_comb begin
    w_rst_nxt  = (r_state == IDLE && i_start) ? '1 : (w_adv ? o_stage_reset << 1 : o_stage_reset);
    w_busy_nxt = w_state_nxt != IDLE;
    w_done_nxt = w_state_nxt == DONE;
  end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4: number of downstream reset domains sequenced; legal range 1..16.
REQ-002 Parameter HOLD_CYCLES, default 8: cycles all stage resets are held asserted; legal range >= 1.
REQ-003 Parameter GAP_CYCLES, default 4: cycles between consecutive stage releases; legal range >= 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 sync_reset_n  input  1  synchronous, active-low reset; sampled on rising clk only.
REQ-006 i_start  input  1  request for a soft reset sequence; level-sampled each cycle.
REQ-007 i_hold  input  1  extends the all-asserted phase while high.
REQ-008 o_stage_reset  output  NUM_STAGES  active-high synchronous reset per domain; bit 0 is released first.
REQ-009 o_busy  output  1  high whenever the state is not IDLE.
REQ-010 o_done  output  1  one-cycle pulse marking sequence completion.

Function
REQ-011 The state machine SHALL have the states IDLE, ASSERT, RELEASE and DONE.
REQ-012 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-013 In IDLE, i_start high at an edge SHALL set o_stage_reset to all ones, clear cnt to 0 and enter ASSERT at that edge.
REQ-014 i_start SHALL be ignored in ASSERT, RELEASE and DONE, and SHALL NOT be queued.
REQ-015 In ASSERT, cnt SHALL increment each cycle i_hold is low and freeze while i_hold is high.
REQ-016 ASSERT SHALL exit when cnt == HOLD_CYCLES-1 with i_hold low, giving exactly HOLD_CYCLES non-held cycles of all-ones.
REQ-017 On ASSERT exit, at the same edge, o_stage_reset[0] SHALL clear, cnt SHALL become 0, stage index idx SHALL become 0 and the state SHALL enter RELEASE.
REQ-018 In RELEASE, cnt SHALL increment each cycle; i_hold SHALL have no effect.
REQ-019 At cnt == GAP_CYCLES-1 in RELEASE, bit idx+1 SHALL clear, idx SHALL increment and cnt SHALL reset to 0.
REQ-020 Stages SHALL release strictly in ascending order, and a released bit SHALL remain 0 until the next sequence or reset.
REQ-021 The edge that clears bit NUM_STAGES-1 SHALL also enter DONE and set o_done to 1.
REQ-022 If NUM_STAGES == 1, the ASSERT exit SHALL go directly to DONE.
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE with o_done = 0 and o_busy = 0.
REQ-024 cnt width SHALL be clog2(max(HOLD_CYCLES, GAP_CYCLES)) with a minimum of 1; cnt SHALL never wrap within a phase.
REQ-025 idx width SHALL be clog2(NUM_STAGES) with a minimum of 1.
REQ-026 Total cycles from i_start accepted to o_done high SHALL be HOLD_CYCLES + (NUM_STAGES-1)*GAP_CYCLES, plus any held cycles.

Reset
REQ-027 When sync_reset_n is low at an edge: state = ASSERT, cnt = 0, idx = 0, o_stage_reset = all ones, o_busy = 1, o_done = 0.
REQ-028 After reset release, the block SHALL run a full sequence autonomously with no i_start required (power-on sequencing).
REQ-029 Reset low mid-sequence (any state) SHALL re-assert all stage resets at that edge and restart from ASSERT cnt = 0.
REQ-030 Reset low SHALL take priority over i_start and i_hold in the same cycle.

Verification
REQ-031 Defaults; reset low 3 cycles, then high, i_hold = 0 -> o_stage_reset = 1111 for 8 cycles, then 1110, 1100, 1000, 0000 at 4-cycle spacing; o_done high 1 cycle at the 0000 edge; o_busy low next cycle.
REQ-032 From IDLE, i_start pulsed at edge 0 -> 1111 at edge 0, 1110 at edge 8, 1100 at 12, 1000 at 16, 0000 with o_done = 1 at 20, IDLE at 21.
REQ-033 i_hold high for 5 cycles during ASSERT -> first release delayed by exactly 5 cycles (edge 13); i_hold high during RELEASE -> no timing change.
REQ-034 i_start held high continuously through the whole sequence -> no restart until IDLE is reached; a new sequence begins at the first IDLE edge.
REQ-035 sync_reset_n low for 1 cycle while o_stage_reset = 1100 -> 1111 at that edge, then a full sequence from cnt 0 with no residual idx.
REQ-036 NUM_STAGES = 1, HOLD_CYCLES = 1, GAP_CYCLES = 1 -> i_start gives reset = 1 for 1 cycle, then reset = 0 with o_done = 1 on the next edge.
